// File: rtl/mfp_srec_ahb_writer.sv
// Buffers SREC parser byte writes (optionally coalesced into word entries) and
// replays them as single AHB-Lite write transfers in FIFO order.
module mfp_srec_ahb_writer #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned COALESCE     = 1,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic        flush,
    input  logic        HREADY,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HWRITE    = 1'b1;

    logic [1:0]       lane;
    entry_t           new_entry;
    entry_t           pend_q, pend_n, push_entry;
    logic             pend_valid_q, pend_valid_n;
    logic [CNT_W-1:0] idle_q, idle_n;
    logic             mergeable, push;

    assign lane = write_address[1:0];

    always_comb begin
        new_entry.waddr = write_address[31:2];
        new_entry.data  = 32'(write_byte) << {lane, 3'b000};
        new_entry.mask  = 4'b0001 << lane;
    end

    // Pending-entry coalescer: merge, push on full/conflict/timeout/flush
    always_comb begin
        pend_n       = pend_q;
        pend_valid_n = pend_valid_q;
        idle_n       = idle_q;
        mergeable    = 1'b0;
        push         = 1'b0;
        push_entry   = new_entry;
        if (COALESCE != 0) begin
            mergeable  = write_enable && pend_valid_q &&
                         (pend_q.waddr == write_address[31:2]) && !pend_q.mask[lane];
            push       = pend_valid_q && ((pend_q.mask == 4'hF) || (write_enable && !mergeable) ||
                                          (idle_q == IDLE_LAST) || flush);
            push_entry = pend_q;
            if (push) pend_valid_n = 1'b0;
            if (write_enable) begin
                if (mergeable && !push) begin
                    pend_n.data = pend_q.data | new_entry.data;
                    pend_n.mask = pend_q.mask | new_entry.mask;
                end else begin
                    pend_n       = new_entry;
                    pend_valid_n = 1'b1;
                end
            end
            if (write_enable || !pend_valid_q || push) idle_n = '0;
            else                                       idle_n = idle_q + CNT_W'(1);
        end else begin
            push = write_enable;
        end
    end

    entry_t         mem [FIFO_DEPTH];
    entry_t         head;
    logic [PTR_W:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic           fifo_empty, fifo_full, pop, push_ok, drop;
    state_t         state;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign wr_ptr_n   = wr_ptr + PW'(push_ok);
    assign rd_ptr_n   = rd_ptr + PW'(pop);
    assign head       = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    entry_t     work;
    logic [1:0] cur_lane;
    logic       full_xfer, fsm_active_n;
    logic [3:0] rem_mask;

    assign full_xfer = (work.mask == 4'hF);
    assign rem_mask  = full_xfer ? 4'h0 : (work.mask & ~(4'b0001 << cur_lane));

    always_comb begin
        fsm_active_n = 1'b1;
        case (state)
            S_IDLE:  fsm_active_n = !fifo_empty;
            S_DATA:  fsm_active_n = !(HREADY && (rem_mask == 4'h0));
            default: fsm_active_n = 1'b1;
        endcase
    end

    // Buffer state, sticky overflow and busy flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            idle_q       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pend_q       <= pend_n;
            pend_valid_q <= pend_valid_n;
            idle_q       <= idle_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            overflow     <= overflow | drop;
            busy         <= pend_valid_n | (wr_ptr_n != rd_ptr_n) | fsm_active_n;
        end
    end

    // AHB master: one NONSEQ single per word entry, or per set lane of a partial entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            work     <= '0;
            cur_lane <= 2'd0;
            HTRANS   <= 2'b00;
            HADDR    <= '0;
            HSIZE    <= 3'b000;
            HWDATA   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        work     <= head;
                        cur_lane <= low_lane(head.mask);
                        HADDR    <= {head.waddr, low_lane(head.mask)};
                        HSIZE    <= (head.mask == 4'hF) ? 3'b010 : 3'b000;
                        HTRANS   <= 2'b10;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= 2'b00;
                        HWDATA <= full_xfer ? work.data : {4{work.data[{cur_lane, 3'b000} +: 8]}};
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        work.mask <= rem_mask;
                        if (rem_mask != 4'h0) begin
                            cur_lane <= low_lane(rem_mask);
                            HADDR    <= {work.waddr, low_lane(rem_mask)};
                            HSIZE    <= 3'b000;
                            HTRANS   <= 2'b10;
                            state    <= S_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_srec_ahb_writer.sv
// Scoreboard bench: a coalescing and a non-coalescing writer share stimulus;
// an SREC-level model predicts the AHB transfers each must produce.
module tb_mfp_srec_ahb_writer;

    typedef struct packed {
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } xfer_t;

    logic        clock, reset_n, write_enable, flush;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        hr_rand, hr_rnd, hr_fix, hready;

    logic        c1_busy, c1_ovf, c1_hmastlock, c1_hwrite;
    logic [31:0] c1_haddr, c1_hwdata;
    logic [2:0]  c1_hburst, c1_hsize;
    logic [3:0]  c1_hprot;
    logic [1:0]  c1_htrans;
    logic        c0_busy, c0_ovf, c0_hmastlock, c0_hwrite;
    logic [31:0] c0_haddr, c0_hwdata;
    logic [2:0]  c0_hburst, c0_hsize;
    logic [3:0]  c0_hprot;
    logic [1:0]  c0_htrans;

    assign hready = hr_rand ? hr_rnd : hr_fix;

    mfp_srec_ahb_writer u_c1 (
        .clock(clock), .reset_n(reset_n), .write_address(write_address),
        .write_byte(write_byte), .write_enable(write_enable), .flush(flush),
        .HREADY(hready), .busy(c1_busy), .overflow(c1_ovf), .HADDR(c1_haddr),
        .HBURST(c1_hburst), .HMASTLOCK(c1_hmastlock), .HPROT(c1_hprot),
        .HSIZE(c1_hsize), .HTRANS(c1_htrans), .HWDATA(c1_hwdata), .HWRITE(c1_hwrite)
    );

    mfp_srec_ahb_writer #(.COALESCE(0)) u_c0 (
        .clock(clock), .reset_n(reset_n), .write_address(write_address),
        .write_byte(write_byte), .write_enable(write_enable), .flush(flush),
        .HREADY(hready), .busy(c0_busy), .overflow(c0_ovf), .HADDR(c0_haddr),
        .HBURST(c0_hburst), .HMASTLOCK(c0_hmastlock), .HPROT(c0_hprot),
        .HSIZE(c0_hsize), .HTRANS(c0_htrans), .HWDATA(c0_hwdata), .HWRITE(c0_hwrite)
    );

    int total = 0;
    int bad   = 0;
    xfer_t q1[$];
    xfer_t q0[$];

    // Reference: open word group, closed on conflict, full word, flush or idle timeout
    logic        m_valid = 1'b0;
    logic [29:0] m_waddr;
    logic [3:0]  m_mask = 4'h0;
    logic [7:0]  m_b [4];
    int          m_idle = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        hr_rnd = 1'b1;
        forever begin
            @(posedge clock);
            #1 hr_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_close();
        xfer_t x;
        if (!m_valid) return;
        if (m_mask == 4'hF) begin
            x.a = {m_waddr, 2'b00};
            x.s = 3'd2;
            x.d = {m_b[3], m_b[2], m_b[1], m_b[0]};
            q1.push_back(x);
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (m_mask[l]) begin
                    x.a = {m_waddr, 2'(l)};
                    x.s = 3'd0;
                    x.d = {4{m_b[l]}};
                    q1.push_back(x);
                end
            end
        end
        m_valid = 1'b0;
        m_mask  = 4'h0;
        m_idle  = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_xfer(input int which, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] d);
        xfer_t got, exp;
        logic  none;
        got.a = a; got.s = s; got.d = d;
        total++;
        none = (which == 1) ? (q1.size() == 0) : (q0.size() == 0);
        if (none) begin
            bad++;
            $display("FAIL xfer_c%0d unexpected: got addr=%h size=%0d data=%h, required no transfer",
                     which, a, s, d);
        end else begin
            if (which == 1) exp = q1.pop_front();
            else            exp = q0.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL xfer_c%0d: got addr=%h size=%0d data=%h, required addr=%h size=%0d data=%h",
                         which, a, s, d, exp.a, exp.s, exp.d);
            end
        end
    endtask

    logic        d1 = 1'b0, d0 = 1'b0;
    logic [31:0] a1, a0;
    logic [2:0]  s1, s0;

    always @(negedge clock) begin
        if (!reset_n) d1 = 1'b0;
        else begin
            if (d1 && hready) begin
                check_xfer(1, a1, s1, c1_hwdata);
                d1 = 1'b0;
            end
            if (c1_htrans == 2'b10 && hready) begin
                d1 = 1'b1; a1 = c1_haddr; s1 = c1_hsize;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset_n) d0 = 1'b0;
        else begin
            if (d0 && hready) begin
                check_xfer(0, a0, s0, c0_hwdata);
                d0 = 1'b0;
            end
            if (c0_htrans == 2'b10 && hready) begin
                d0 = 1'b1; a0 = c0_haddr; s0 = c0_hsize;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] b);
        xfer_t x;
        x.a = a; x.s = 3'd0; x.d = {4{b}};
        q0.push_back(x);
        if (m_valid && m_idle >= 15) m_close();
        if (m_valid && a[31:2] == m_waddr && !m_mask[a[1:0]]) begin
            m_mask[a[1:0]] = 1'b1;
            m_b[a[1:0]]    = b;
        end else begin
            m_close();
            m_valid        = 1'b1;
            m_waddr        = a[31:2];
            m_mask         = 4'h0;
            m_mask[a[1:0]] = 1'b1;
            m_b[a[1:0]]    = b;
        end
        m_idle = 0;
        if (m_mask == 4'hF) m_close();
        write_address = a;
        write_byte    = b;
        write_enable  = 1'b1;
        cyc();
        write_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (m_valid) begin
                m_idle++;
                if (m_idle >= 16) m_close();
            end
            cyc();
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        m_close();
        cyc();
        flush = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        m_close();
        while ((c1_busy || c0_busy) && n < 400) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        total++;
        if (c1_busy || c0_busy || q1.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL quiet_%s: busy1=%0d busy0=%0d left1=%0d left0=%0d, required all 0",
                     tag, c1_busy, c0_busy, q1.size(), q0.size());
        end
    endtask

    task automatic wait_addr(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (c1_htrans == 2'b10) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk({"addr_phase_", tag}, 32'(ok), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; write_enable = 1'b0; flush = 1'b0;
        write_address = '0; write_byte = '0;
        hr_rand = 1'b0; hr_fix = 1'b1;
        #12;
        chk("rst_htrans", 32'(c1_htrans), 32'd0);
        chk("rst_haddr", c1_haddr, 32'd0);
        chk("rst_hwdata", c1_hwdata, 32'd0);
        chk("rst_hsize", 32'(c1_hsize), 32'd0);
        chk("rst_busy", 32'({c1_busy, c0_busy}), 32'd0);
        chk("rst_overflow", 32'({c1_ovf, c0_ovf}), 32'd0);
        chk("const_hburst", 32'(c1_hburst), 32'd0);
        chk("const_hprot", 32'(c1_hprot), 32'd3);
        chk("const_hwrite_lock", 32'({c1_hwrite, c1_hmastlock}), 32'd2);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("first_cycle_idle", 32'({c1_htrans, c0_htrans}), 32'd0);

        // full word coalesced into one transfer
        wr(32'h100, 8'h11); wr(32'h101, 8'h22); wr(32'h102, 8'h33); wr(32'h103, 8'h44);
        wait_quiet("word");

        // partial word pushed by idle timeout only
        wr(32'h200, 8'hAA); wr(32'h201, 8'hBB);
        idle(10);
        chk("timeout_not_early", 32'(c1_htrans), 32'd0);
        chk("timeout_busy", 32'(c1_busy), 32'd1);
        idle(10);
        wait_quiet("timeout");

        // random bursts with random HREADY stalls
        hr_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            logic [31:0] base;
            int n;
            base = $urandom & 32'hFFFF_FFF8;
            n    = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                int r;
                wr(base + 32'($urandom_range(0, 7)), 8'($urandom));
                r = $urandom_range(0, 7);
                if (r == 0) do_flush();
                else if (r < 4) idle(r - 1);
            end
            if ($urandom_range(0, 1) == 1) do_flush();
            wait_quiet("random");
        end
        hr_rand = 1'b0;
        cyc();
        chk("random_no_overflow", 32'({c1_ovf, c0_ovf}), 32'd0);

        // address phase held 3 stalled cycles, data phase 2
        hr_fix = 1'b0;
        wr(32'h400, 8'hDE); wr(32'h401, 8'hAD); wr(32'h402, 8'hBE); wr(32'h403, 8'hEF);
        wait_addr("stall");
        for (int i = 0; i < 3; i++) begin
            chk("stall_haddr", c1_haddr, 32'h400);
            chk("stall_hsize", 32'(c1_hsize), 32'd2);
            chk("stall_htrans", 32'(c1_htrans), 32'd2);
            cyc();
        end
        hr_fix = 1'b1;
        cyc();
        hr_fix = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_data_htrans", 32'(c1_htrans), 32'd0);
            chk("stall_hwdata", c1_hwdata, 32'hEFBEADDE);
            cyc();
        end
        hr_fix = 1'b1;
        wait_quiet("stall");

        // one entry held in the stalled work register, ten more offered: FIFO keeps 8
        hr_fix = 1'b0;
        wr(32'h600, 8'h01);
        do_flush();
        idle(3);
        for (int i = 0; i < 10; i++) wr(32'h700 + 32'(4 * i), 8'(8'h10 + i));
        do_flush();
        idle(2);
        void'(q1.pop_back()); void'(q1.pop_back());
        void'(q0.pop_back()); void'(q0.pop_back());
        chk("overflow_c1", 32'(c1_ovf), 32'd1);
        chk("overflow_c0", 32'(c0_ovf), 32'd1);
        hr_fix = 1'b1;
        wait_quiet("overflow");
        chk("overflow_sticky", 32'({c1_ovf, c0_ovf}), 32'd3);

        // reset during a stalled data phase
        hr_fix = 1'b0;
        wr(32'h500, 8'h01); wr(32'h501, 8'h02); wr(32'h502, 8'h03); wr(32'h503, 8'h04);
        wait_addr("reset");
        hr_fix = 1'b1;
        cyc();
        hr_fix = 1'b0;
        cyc();
        reset_n = 1'b0;
        #1;
        chk("midrst_htrans", 32'(c1_htrans), 32'd0);
        chk("midrst_busy", 32'({c1_busy, c0_busy}), 32'd0);
        chk("midrst_hwdata", c1_hwdata, 32'd0);
        chk("midrst_haddr", c1_haddr, 32'd0);
        chk("midrst_overflow", 32'({c1_ovf, c0_ovf}), 32'd0);
        q1.delete(); q0.delete();
        m_valid = 1'b0; m_mask = 4'h0; m_idle = 0;
        cyc(); cyc();
        reset_n = 1'b1;
        hr_fix = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_idle", 32'({c1_htrans, c0_htrans}), 32'd0);
        end

        // two bytes to adjacent lanes
        wr(32'h300, 8'h5A); wr(32'h301, 8'hA5);
        wait_quiet("bytes");
        chk("final_busy", 32'({c1_busy, c0_busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_srec_ahb_writer.md
MFP_SREC_AHB_WRITER -- requirements
Module: mfp_srec_ahb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning number of buffered write entries (power of 2, at least 2).
REQ-002 SHALL have parameter COALESCE, default 1, meaning 1 = merge bytes into word entries, 0 = one byte per entry.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 16, meaning idle cycles before a partial pending entry is pushed.
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port write_address  in  32  byte address from SREC parser.
REQ-007 SHALL have port write_byte  in  8  data byte.
REQ-008 SHALL have port write_enable  in  1  one-cycle strobe; byte accepted unconditionally.
REQ-009 SHALL have port flush  in  1  force push of the pending entry.
REQ-010 SHALL have port HREADY  in  1  AHB-Lite slave ready.
REQ-011 SHALL have port busy  out  1  pending valid, FIFO non-empty, or FSM not IDLE.
REQ-012 SHALL have port overflow  out  1  sticky; an entry was dropped.
REQ-013 SHALL have ports HADDR out 32, HBURST out 3, HMASTLOCK out 1, HPROT out 4, HSIZE out 3, HTRANS out 2, HWDATA out 32, HWRITE out 1, forming the AHB-Lite master outputs.

Function
REQ-014 SHALL hold constant HBURST=000 (SINGLE), HMASTLOCK=0, HPROT=0011, HWRITE=1.
REQ-015 SHALL use an entry format of word address (addr[31:2]), 32-bit data, 4-bit lane mask.
REQ-016 With COALESCE=1, SHALL merge a write into the pending entry when the pending entry is valid, addr[31:2] matches, and the lane addr[1:0] is unset: byte goes to bits [8*lane+7:8*lane], mask bit set.
REQ-017 SHALL push the pending entry to the FIFO in the cycle where any of these holds:
- mask==1111;
- write_enable with a non-mergeable byte;
- idle counter == FLUSH_CYCLES-1;
- flush=1.
REQ-018 On a non-mergeable byte, or a byte arriving while mask==1111, SHALL push the old entry and load the new byte as a fresh pending entry in the same cycle.
REQ-019 The idle counter SHALL clear on write_enable, increment while pending is valid and no write occurs, and hold at zero while pending is invalid.
REQ-020 With COALESCE=0, SHALL push each byte directly into the FIFO in its write_enable cycle, with a single-lane mask.
REQ-021 A push while the FIFO is full SHALL drop the entry and set overflow; overflow clears only on reset.
REQ-022 Simultaneous push and pop on a full FIFO SHALL be accepted without loss.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-024 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-025 In IDLE, SHALL drive HTRANS=00; if the FIFO is non-empty, SHALL pop the head into the work register and go to ADDR.
REQ-026 In ADDR, SHALL drive HTRANS=10 (NONSEQ).
- Mask 1111: HADDR={waddr,00}, HSIZE=010.
- Otherwise: HADDR={waddr,lane} for the lowest remaining set lane, HSIZE=000.
- All address-phase signals SHALL be held stable until HREADY=1 at an edge, then go to DATA.
REQ-027 In DATA, SHALL drive HTRANS=00.
- HWDATA: the full word, or the selected byte replicated on all four lanes.
- HWDATA SHALL be held until HREADY=1; then clear that lane and go to ADDR if lanes remain, else IDLE.
REQ-028 SHALL deliver entries in FIFO order, and lanes within an entry in ascending order.
REQ-029 Minimum transfer cost SHALL be 2 cycles per AHB transfer plus 1 cycle per entry pop.

Reset
REQ-030 Reset SHALL take effect asynchronously at any point, including mid-transfer.
REQ-031 Outputs during reset SHALL be: HTRANS=00, HADDR=0, HWDATA=0, HSIZE=000, busy=0, overflow=0.
REQ-032 Reset SHALL clear the FSM to IDLE, invalidate the pending entry and work register, empty the FIFO, and clear the idle counter.
REQ-033 The first cycle after reset release SHALL be IDLE with no transfer issued.

Verification
REQ-034 Scenario, COALESCE=1, HREADY=1: bytes 11,22,33,44 to 0x100..0x103 -> one transfer, HADDR=0x100, HSIZE=010, HWDATA=0x44332211.
REQ-035 Scenario: bytes AA to 0x200 and BB to 0x201, then idle -> after 16 idle cycles, byte transfers 0x200/HWDATA=0xAAAAAAAA then 0x201/0xBBBBBBBB.
REQ-036 Scenario: HREADY=0 for 3 cycles in ADDR, then 2 cycles in DATA -> HADDR, HTRANS and HSIZE held over the 3 cycles, and HWDATA held over the 2 cycles.
REQ-037 Scenario: HREADY=0, push 10 entries (bytes to distinct words) -> overflow=1, and after HREADY=1 exactly 8 entries are delivered in order.
REQ-038 Scenario: reset_n low during DATA -> HTRANS=00 and busy=0 immediately; no stale transfer after release.
REQ-039 Scenario, COALESCE=0: bytes to 0x300 and 0x301 -> two byte transfers; busy=0 afterwards.
